mips_multicycle_core: RTL
=========================

Name: mips_multicycle_core

Overview:
Next-generation MIPS core: multi-cycle FSM implementation of the MIPS subset the single-cycle Mips top executes. Uses one unified instruction/data memory port with a req/ready handshake, so external memory may insert wait states. Reset vector and memory address width are parametrised. Adds halt-on-illegal-opcode and a per-instruction retire pulse. Sits between a testbench/SoC wrapper and a shared memory model.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
MEM_AW, 32, width of mem_addr; byte address = low MEM_AW bits of the internal 32-bit address.

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
mem_req  out  1  memory transaction request
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  MEM_AW  byte address; valid while mem_req=1
mem_wdata  out  32  store data; valid while mem_req=1 and mem_we=1
mem_rdata  in  32  read data; sampled in the cycle mem_ready=1
mem_ready  in  1  transaction completes in any cycle where mem_req=1 and mem_ready=1
retire  out  1  one-cycle pulse in the final cycle of each completed instruction
halted  out  1  sticky 1 after an illegal opcode
pc_dbg  out  32  current architectural PC

Behaviour:
- Reset (sampled low at posedge): PC<=RESET_PC; state<=FETCH; all 32 GPRs<=0; IR, A, B, ALUOut, MDR<=0. While reset=0, mem_req, mem_we, retire and halted are forced to 0 and pc_dbg=RESET_PC. A transaction in flight when reset is sampled is abandoned; there is no resume.
- Handshake: mem_req is high in the FETCH, MEMRD and MEMWR states only. mem_addr, mem_we and mem_wdata hold stable until ready. The FSM waits in the state while mem_ready=0. mem_ready is ignored when mem_req=0.
- Supported ISA: R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex), lw(23), sw(2B), beq(04), addi(08), j(02).
- States and transitions:
  - FETCH: addr=PC. On ready: IR<=rdata, PC<=PC+4, go to DECODE.
  - DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(simm<<2). Dispatch: lw/sw->MEMADR, R->EXEC, beq->BRANCH, addi->ADDIEX, j->JUMP, anything else->HALT.
  - MEMADR: ALUOut<=A+simm; lw->MEMRD, sw->MEMWR.
  - MEMRD: addr=ALUOut, we=0. On ready: MDR<=rdata, go to MEMWB.
  - MEMWB: R[rt]<=MDR; retire; go to FETCH.
  - MEMWR: addr=ALUOut, we=1, wdata=B. On ready: retire, go to FETCH.
  - EXEC: ALUOut<=A op B; go to ALUWB.
  - ALUWB: R[rd]<=ALUOut; retire; go to FETCH.
  - BRANCH: if A==B then PC<=ALUOut; retire; go to FETCH.
  - ADDIEX: ALUOut<=A+simm; go to ADDIWB.
  - ADDIWB: R[rt]<=ALUOut; retire; go to FETCH.
  - JUMP: PC<={PC[31:28], IR[25:0], 2'b00}; retire; go to FETCH.
  - HALT: halted=1; no retire; no mem_req; stays in HALT until reset.
  - An unknown R-type funct also goes to HALT, from EXEC, with no write.
- Arithmetic: 32-bit two's complement. add/addi wrap with no overflow trap. slt is a signed compare, result 0 or 1. simm is IR[15:0] sign-extended. lw/sw address low 2 bits pass through unchecked.
- Register 0: reads return 0; writes are discarded.
- Latency, in cycles with zero wait states (mem_ready tied 1): beq 3, j 3, R-type 4, addi 4, sw 4, lw 5. Each wait cycle adds 1.
- retire is asserted in the same cycle as the final-state register/PC update.

Optional Feature:
MIPS_MC_EXT_ISA_EN
- Defined: adds bne(05), andi(0C), ori(0D).
  - bne uses the BRANCH state with the condition inverted.
  - andi/ori zero-extend the immediate, go through ADDIEX with the AND/OR op, then ADDIWB.
  - Latencies: bne 3, andi/ori 4.
- Undefined: opcodes 05, 0C and 0D are illegal and go to HALT.

Test Plan:
- Reset with RESET_PC=32'h40 and zero-wait memory -> first mem_req has addr=0x40. Registers read 0.
- addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> R3=2, R4=1. retire pulses at cycles 4, 8, 12, 16.
- sw $3,8($0) then lw $5,8($0), with mem_ready low for 3 cycles on each access -> mem[8]=2, R5=2. Address and wdata stay stable while stalled. sw takes 7 cycles, lw 8.
- beq $1,$1,+2 -> PC=old+12. beq $1,$2 not taken -> PC+4. j 0x10 -> PC=0x40 with PC[31:28] preserved.
- Opcode 3F -> halted=1 after DECODE. No further mem_req. Reset clears halted and refetches at RESET_PC.
- Assert reset during a lw stall (mem_ready=0) -> mem_req drops in the same cycle. After release, fetch restarts at RESET_PC and R5 reads 0.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle FSM MIPS core with a single shared
// instruction/data memory port (req/ready handshake, wait states allowed).
// Illegal opcodes or R-type functs park the core in HALT until reset.
// Optional: define MIPS_MC_EXT_ISA_EN to add bne, andi and ori.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_AW   = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic              halted,
    output logic [31:0]       pc_dbg
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_MC_EXT_ISA_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
`endif

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
    } state_t;

    state_t      state, state_nx;

    logic [31:0] pc, ir, a, b, aluout, mdr;
    logic [31:0] gpr [32];

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm;
    logic [31:0] rs_val, rt_val;

    logic [31:0] alu_r;
    logic        funct_ok;
    logic [31:0] imm_r;
    logic        take;

    logic [31:0] addr32;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    assign op     = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign simm   = {{16{ir[15]}}, ir[15:0]};
    assign rs_val = (rs == 5'd0) ? 32'd0 : gpr[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : gpr[rt];

    assign mem_addr = addr32[MEM_AW-1:0];
    assign pc_dbg   = reset ? pc : RESET_PC;

    // R-type ALU; an unrecognised funct flags the instruction illegal
    always_comb begin
        alu_r    = 32'd0;
        funct_ok = 1'b1;
        case (ir[5:0])
            FN_ADD:  alu_r = a + b;
            FN_SUB:  alu_r = a - b;
            FN_AND:  alu_r = a & b;
            FN_OR:   alu_r = a | b;
            FN_SLT:  alu_r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: funct_ok = 1'b0;
        endcase
    end

    // Immediate ALU and branch condition (bne reuses BRANCH with inverted test)
    always_comb begin
        imm_r = a + simm;
        take  = (a == b);
`ifdef MIPS_MC_EXT_ISA_EN
        case (op)
            OP_ANDI: imm_r = a & {16'h0000, ir[15:0]};
            OP_ORI:  imm_r = a | {16'h0000, ir[15:0]};
            default: imm_r = a + simm;
        endcase
        if (op == OP_BNE)
            take = (a != b);
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset)
            state <= S_FETCH;
        else
            state <= state_nx;
    end

    // Next-state logic: memory states hold until ready, decode dispatches by opcode
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nx = S_MEMADR;
                    OP_RTYPE:     state_nx = S_EXEC;
                    OP_BEQ:       state_nx = S_BRANCH;
                    OP_ADDI:      state_nx = S_ADDIEX;
                    OP_J:         state_nx = S_JUMP;
`ifdef MIPS_MC_EXT_ISA_EN
                    OP_BNE:           state_nx = S_BRANCH;
                    OP_ANDI, OP_ORI:  state_nx = S_ADDIEX;
`endif
                    default:      state_nx = S_HALT;
                endcase
            end
            S_MEMADR: state_nx = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_nx = S_FETCH;
            S_MEMWB:  state_nx = S_FETCH;
            S_EXEC:   state_nx = funct_ok ? S_ALUWB : S_HALT;
            S_ALUWB:  state_nx = S_FETCH;
            S_BRANCH: state_nx = S_FETCH;
            S_ADDIEX: state_nx = S_ADDIWB;
            S_ADDIWB: state_nx = S_FETCH;
            S_JUMP:   state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_HALT;
        endcase
    end

    // Outputs: memory port, retire, halt and register write port; all forced idle in reset
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr32    = pc;
        mem_wdata = 32'd0;
        retire    = 1'b0;
        halted    = 1'b0;
        rf_we     = 1'b0;
        rf_wa     = rt;
        rf_wd     = aluout;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                addr32  = pc;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                addr32  = aluout;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                addr32    = aluout;
                mem_wdata = b;
                retire    = mem_ready;
            end
            S_MEMWB: begin
                rf_we  = 1'b1;
                rf_wa  = rt;
                rf_wd  = mdr;
                retire = 1'b1;
            end
            S_ALUWB: begin
                rf_we  = 1'b1;
                rf_wa  = rd;
                rf_wd  = aluout;
                retire = 1'b1;
            end
            S_ADDIWB: begin
                rf_we  = 1'b1;
                rf_wa  = rt;
                rf_wd  = aluout;
                retire = 1'b1;
            end
            S_BRANCH, S_JUMP: retire = 1'b1;
            S_HALT:   halted = 1'b1;
            default:  ;
        endcase
        if (!reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            retire  = 1'b0;
            halted  = 1'b0;
            rf_we   = 1'b0;
        end
    end

    // Datapath registers: PC, IR, operand latches, ALUOut, MDR
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= RESET_PC;
            ir     <= 32'd0;
            a      <= 32'd0;
            b      <= 32'd0;
            aluout <= 32'd0;
            mdr    <= 32'd0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) begin
                    ir <= mem_rdata;
                    pc <= pc + 32'd4;
                end
                S_DECODE: begin
                    a      <= rs_val;
                    b      <= rt_val;
                    aluout <= pc + {simm[29:0], 2'b00};
                end
                S_MEMADR: aluout <= a + simm;
                S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
                S_EXEC:   aluout <= alu_r;
                S_ADDIEX: aluout <= imm_r;
                S_BRANCH: if (take) pc <= aluout;
                S_JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
                default:  ;
            endcase
        end
    end

    // Register file; $0 is never written so it stays zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                gpr[i] <= 32'd0;
        end else if (rf_we && rf_wa != 5'd0) begin
            gpr[rf_wa] <= rf_wd;
        end
    end

endmodule
